ro_meas_sequencer: RTL and testbench
====================================

Name: ro_meas_sequencer

Overview:
- Measurement scheduler for the ring-oscillator temperature sensor.
- On a start command it enables the selected oscillator (inverter or NAND) and lets it settle. It then opens fixed-length counter gate windows, accumulates 2^AVG_LOG2 samples and computes the average.
- The average is sent as a 3-byte frame through the UART transmit handshake.
- In alternate mode it measures both oscillators back to back. It sits between the command decoder, the oscillator/counter datapath and the UART.

Parameters:
- CNT_W, 16, width of the ring counter value.
- GATE_CYCLES, 1000, clk cycles per gate window (≥1).
- SETTLE_CYCLES, 64, clk cycles the oscillator runs before the first window (≥1).
- AVG_LOG2, 3, log2 of samples averaged per oscillator (0..8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle abort request.
- mode  in  2  0=inv only, 1=nand only, 2=inv then nand, 3=reserved (treated as 0).
- count  in  CNT_W  ring counter value, synchronous to clk.
- tx_busy  in  1  UART transmitter busy.
- en_inv  out  1  inverter oscillator enable.
- en_nand  out  1  NAND oscillator enable.
- osc_sel  out  1  0=inverter path, 1=NAND path to the counter.
- cnt_clr  out  1  synchronous counter clear.
- cnt_en  out  1  counter gate.
- tx_start  out  1  one-cycle UART send strobe.
- tx_data  out  8  byte to send; valid while tx_start=1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at end of a complete run.
- overflow  out  1  sticky saturation flag.

Behaviour:
- Clock and reset:
  - Single clock; rst_n is asynchronous and active-low.
  - During reset every output is 0, the state is IDLE and all counters/accumulator are 0.
- States: IDLE, SETTLE, GATE, CAPT, SEND, TXWAIT, DONE.
- IDLE:
  - On start=1: latch mode (3→0), set osc_id (0 for modes 0/2, 1 for mode 1).
  - Clear the accumulator, sample index and overflow, then go to SETTLE.
  - start in any other state is ignored.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - en_inv=(osc_id==0), en_nand=(osc_id==1), osc_sel=osc_id, cnt_clr=1. Then go to GATE.
- Oscillator enables:
  - The enable and osc_sel stay asserted in SETTLE, GATE, CAPT, SEND and TXWAIT.
  - They drop to 0 in IDLE and DONE.
- GATE:
  - Lasts exactly GATE_CYCLES cycles with cnt_en=1 and cnt_clr=0.
- CAPT:
  - Lasts 1 cycle with cnt_en=0. acc <= acc + count.
  - acc width is CNT_W+AVG_LOG2, so the sum cannot overflow.
  - If count == all-ones, set overflow.
  - cnt_clr=1 this cycle.
  - If the sample index < 2^AVG_LOG2−1: increment the index and go to GATE (no re-settle).
  - Otherwise: avg = acc >> AVG_LOG2 (truncated), then go to SEND.
- SEND / TXWAIT frame:
  - Three bytes in order: header {4'hA, 2'b00, overflow, osc_id}, avg[15:8], avg[7:0].
  - If CNT_W<16 the average is zero-extended; if CNT_W>16 the low 16 bits are sent.
  - In SEND, when tx_busy=0: tx_start=1 for one cycle with tx_data set to the current byte, then go to TXWAIT.
  - TXWAIT waits for tx_busy=1, then tx_busy=0.
  - If more bytes remain, return to SEND. After the third byte:
    - mode 2 with osc_id==0: set osc_id=1, clear the accumulator and sample index, go to SETTLE.
    - Otherwise go to DONE.
- DONE: one cycle with done=1, then IDLE.
- overflow:
  - Holds until the next accepted start; it is not cleared between oscillators in mode 2.
- abort:
  - abort=1 in any non-IDLE state forces IDLE on the next edge.
  - No done pulse. Any partial frame is dropped; a tx_start already issued is not retracted.
  - abort and start together in IDLE: start wins.
  - abort has priority over every other transition.
- Outputs are registered (Moore); tx_data holds its last value outside SEND.
- Single-oscillator run latency, start to done, zero tx delay:
  - 1 + SETTLE + N·(GATE+1) + 3·(1+t_tx) + 1 cycles, where N=2^AVG_LOG2 and t_tx is the UART busy time.

Test Plan:
- Reset mid-GATE (params GATE=4, SETTLE=2, AVG_LOG2=1) → all outputs 0 immediately, busy=0, no tx_start after release.
- mode=0, count held at 100 then 102 at the two CAPTs → frames A0,00,65 (avg 101); en_nand never high; cnt_en high exactly 4 cycles per window; done pulses once.
- mode=2, counts inv 200/200, nand 300/302 → two frames A0,00,C8 then A1,01,2D; one done, after the second frame.
- count=16'hFFFF at one CAPT, mode=1 → header A3; overflow stays 1 until the next start, which clears it.
- tx_busy held high 10 cycles when entering SEND → tx_start delayed until tx_busy=0; each byte strobed exactly once.
- abort during the second byte's TXWAIT → IDLE next cycle, no third byte, no done; a start 1 cycle later runs a full fresh frame.

Source files
------------

// File: rtl/ro_meas_sequencer.sv
// ro_meas_sequencer
//   Measurement scheduler for the ring-oscillator temperature sensor.
//   A run enables one oscillator and lets it settle, then opens 2^AVG_LOG2
//   fixed-length gate windows and sums the captured counts. The truncated
//   average goes out as a 3-byte frame over the UART handshake. Mode 2
//   repeats the whole run on the NAND oscillator after the inverter frame.
//
//   state  | meaning
//   IDLE   | waiting for start, oscillators off
//   SETTLE | oscillator running, counter held clear
//   GATE   | counter gate open for GATE_CYCLES cycles
//   CAPT   | accumulate the count, clear the counter
//   SEND   | wait for the UART to be free, then strobe the next byte
//   TXWAIT | wait for tx_busy to rise and then fall
//   DONE   | one-cycle completion pulse
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   start, abort    single-cycle run / abort requests
//   mode            0 inv, 1 nand, 2 inv then nand, 3 treated as 0
//   count           ring counter value (clk domain)
//   tx_busy         UART transmitter busy
//   en_inv, en_nand oscillator enables
//   osc_sel         counter path select (0 inv, 1 nand)
//   cnt_clr, cnt_en counter clear and gate
//   tx_start        one-cycle UART send strobe, tx_data valid with it
//   tx_data         byte to send
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse at the end of a complete run
//   overflow        sticky: some captured count was all ones
module ro_meas_sequencer #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 64,
  parameter int AVG_LOG2      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             tx_busy,
  output logic             en_inv,
  output logic             en_nand,
  output logic             osc_sel,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int ACC_W   = CNT_W + AVG_LOG2;
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = AVG_LOG2 + 1;

  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_GATE, S_CAPT, S_SEND, S_TXWAIT, S_DONE
  } state_t;

  // Level outputs registered as a group; always loaded with the values
  // belonging to the state being entered, so they line up with the state.
  typedef struct packed {
    logic en_inv;
    logic en_nand;
    logic osc_sel;
    logic cnt_clr;
    logic cnt_en;
    logic busy;
  } lvl_t;

  function automatic lvl_t lvl_for(state_t s, logic osc);
    lvl_t l;
    logic osc_on;
    l       = '0;
    osc_on  = (s inside {S_SETTLE, S_GATE, S_CAPT, S_SEND, S_TXWAIT});
    l.busy  = (s != S_IDLE);
    l.cnt_clr = (s == S_SETTLE) || (s == S_CAPT);
    l.cnt_en  = (s == S_GATE);
    l.en_inv  = osc_on & ~osc;
    l.en_nand = osc_on & osc;
    l.osc_sel = osc_on & osc;
    return l;
  endfunction

  state_t           state;
  lvl_t             lvl;
  logic             osc_id;
  logic             two_pass;
  logic [TMR_W-1:0] tmr;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] acc;
  logic [15:0]      avg_q;
  logic [1:0]       byte_idx;
  logic             busy_seen;

  logic [ACC_W-1:0] acc_sum;
  logic [7:0]       byte_cur;

  // acc is AVG_LOG2 bits wider than count, so 2^AVG_LOG2 samples never wrap.
  assign acc_sum = acc + ACC_W'(count);

  always_comb begin
    byte_cur = 8'h00;
    case (byte_idx)
      2'd0:    byte_cur = {4'hA, 2'b00, overflow, osc_id};
      2'd1:    byte_cur = avg_q[15:8];
      default: byte_cur = avg_q[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lvl       <= '0;
      osc_id    <= 1'b0;
      two_pass  <= 1'b0;
      tmr       <= '0;
      idx       <= '0;
      acc       <= '0;
      avg_q     <= '0;
      byte_idx  <= '0;
      busy_seen <= 1'b0;
      overflow  <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      done      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (abort && state != S_IDLE) begin
        // A strobe already on the wire stays; anything not yet sent is dropped.
        state <= S_IDLE;
        lvl   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              two_pass <= (mode == 2'd2);
              osc_id   <= (mode == 2'd1);
              acc      <= '0;
              idx      <= '0;
              overflow <= 1'b0;
              tmr      <= SETTLE_LOAD;
              state    <= S_SETTLE;
              lvl      <= lvl_for(S_SETTLE, (mode == 2'd1));
            end
          end

          S_SETTLE: begin
            if (tmr == '0) begin
              tmr   <= GATE_LOAD;
              state <= S_GATE;
              lvl   <= lvl_for(S_GATE, osc_id);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_GATE: begin
            if (tmr == '0) begin
              state <= S_CAPT;
              lvl   <= lvl_for(S_CAPT, osc_id);
            end else begin
              tmr <= tmr - 1'b1;
            end
          end

          S_CAPT: begin
            acc <= acc_sum;
            if (count == '1) overflow <= 1'b1;
            if (idx != IDX_LAST) begin
              idx   <= idx + 1'b1;
              tmr   <= GATE_LOAD;
              state <= S_GATE;
              lvl   <= lvl_for(S_GATE, osc_id);
            end else begin
              // Truncating cast zero-extends narrow averages and keeps the
              // low 16 bits of wide ones.
              avg_q    <= 16'(acc_sum >> AVG_LOG2);
              byte_idx <= 2'd0;
              state    <= S_SEND;
              lvl      <= lvl_for(S_SEND, osc_id);
            end
          end

          S_SEND: begin
            if (!tx_busy) begin
              tx_start  <= 1'b1;
              tx_data   <= byte_cur;
              busy_seen <= 1'b0;
              state     <= S_TXWAIT;
              lvl       <= lvl_for(S_TXWAIT, osc_id);
            end
          end

          S_TXWAIT: begin
            // Full busy handshake: rising edge first, then the fall.
            if (!busy_seen) begin
              if (tx_busy) busy_seen <= 1'b1;
            end else if (!tx_busy) begin
              if (byte_idx != 2'd2) begin
                byte_idx <= byte_idx + 2'd1;
                state    <= S_SEND;
                lvl      <= lvl_for(S_SEND, osc_id);
              end else if (two_pass && !osc_id) begin
                osc_id <= 1'b1;
                acc    <= '0;
                idx    <= '0;
                tmr    <= SETTLE_LOAD;
                state  <= S_SETTLE;
                lvl    <= lvl_for(S_SETTLE, 1'b1);
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
                lvl   <= lvl_for(S_DONE, osc_id);
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
            lvl   <= '0;
          end

          default: begin
            state <= S_IDLE;
            lvl   <= '0;
          end
        endcase
      end
    end
  end

  assign en_inv  = lvl.en_inv;
  assign en_nand = lvl.en_nand;
  assign osc_sel = lvl.osc_sel;
  assign cnt_clr = lvl.cnt_clr;
  assign cnt_en  = lvl.cnt_en;
  assign busy    = lvl.busy;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// tb_ro_meas_sequencer
//   Directed bench for ro_meas_sequencer with GATE=4, SETTLE=2, AVG_LOG2=1.
//   Counts to capture are queued and driven at the start of each gate window;
//   expected frame bytes are queued per run and popped on every tx_start.
//   A small UART model raises tx_busy for three cycles after each strobe.
module tb_ro_meas_sequencer;
  localparam int CNT_W    = 16;
  localparam int GATE     = 4;
  localparam int SETTLE   = 2;
  localparam int AVG_LOG2 = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W-1:0] count = '0;
  logic             uart_busy = 1'b0;
  logic             hold_busy = 1'b0;
  logic             tx_busy;
  logic             en_inv, en_nand, osc_sel, cnt_clr, cnt_en, tx_start;
  logic [7:0]       tx_data;
  logic             busy, done, overflow;

  assign tx_busy = uart_busy | hold_busy;

  ro_meas_sequencer #(
    .CNT_W(CNT_W), .GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .count(count), .tx_busy(tx_busy), .en_inv(en_inv), .en_nand(en_nand),
    .osc_sel(osc_sel), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]       exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];
  int n_tx = 0, n_done = 0, n_win = 0, tx_at_done = 0, run_len = 0;
  bit nand_seen = 0, prev_en = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] outs();
    return {en_inv, en_nand, osc_sel, cnt_clr, cnt_en, tx_start, busy, done, overflow, tx_data};
  endfunction

  // UART: busy for three cycles after each strobe.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      uart_busy = 1'b1;
      repeat (3) @(negedge clk);
      uart_busy = 1'b0;
    end
  end

  // Monitor: feeds counts, checks window length, path select and frame bytes.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      prev_en = 0;
    end else begin
      if (en_nand) begin
        nand_seen = 1;
        check("nand_path_sel", {30'd0, en_inv, osc_sel}, 32'd1);
      end
      if (cnt_en) begin
        if (!prev_en) count = (cnt_q.size() > 0) ? cnt_q.pop_front() : '0;
        run_len++;
      end else if (prev_en) begin
        check("gate_len", run_len, GATE);
        run_len = 0;
        n_win++;
      end
      prev_en = cnt_en;
      if (tx_start) begin
        logic [8:0] e;
        n_tx++;
        if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
        else e = 9'h1FF;
        check("tx_byte", {23'd0, 1'b0, tx_data}, {23'd0, e});
      end
      if (done) begin
        n_done++;
        tx_at_done = n_tx;
      end
    end
  end

  task automatic run_start(logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(int target, string tag);
    int k = 0;
    while (n_done < target && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, n_done, target);
  endtask

  task automatic wait_win(int target, string tag);
    int k = 0;
    while (n_win < target && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, n_win, target);
  endtask

  task automatic wait_tx(int target, string tag);
    int k = 0;
    while (n_tx < target && k < 500) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, n_tx, target);
  endtask

  task automatic push_frame(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_tx, base_win, dn, k;

    // Reset
    repeat (3) @(negedge clk);
    check("reset_outs", {15'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Mode 0: 100, 102 -> avg 101
    nand_seen = 0;
    cnt_q.push_back(16'd100); cnt_q.push_back(16'd102);
    push_frame(8'hA0, 8'h00, 8'h65);
    base_tx = n_tx;
    run_start(2'd0);
    check("settle_outs", {27'd0, busy, en_inv, en_nand, osc_sel, cnt_clr}, 32'b11001);
    wait_done(1, "done_a");
    repeat (5) @(negedge clk);
    check("done_once_a", n_done, 1);
    check("nand_never_a", {31'd0, nand_seen}, 32'd0);
    check("bytes_a", n_tx - base_tx, 3);
    check("idle_a", {31'd0, busy}, 32'd0);

    // Mode 2: inv 200/200, nand 300/302
    nand_seen = 0;
    cnt_q.push_back(16'd200); cnt_q.push_back(16'd200);
    cnt_q.push_back(16'd300); cnt_q.push_back(16'd302);
    push_frame(8'hA0, 8'h00, 8'hC8);
    push_frame(8'hA1, 8'h01, 8'h2D);
    base_tx = n_tx;
    run_start(2'd2);
    wait_done(2, "done_b");
    check("done_after_six", tx_at_done - base_tx, 6);
    check("nand_used_b", {31'd0, nand_seen}, 32'd1);
    repeat (5) @(negedge clk);
    check("done_once_b", n_done, 2);

    // Mode 1 with a saturated count: header A3, avg 0x8000
    cnt_q.push_back(16'hFFFF); cnt_q.push_back(16'h0001);
    push_frame(8'hA3, 8'h80, 8'h00);
    run_start(2'd1);
    wait_done(3, "done_c");
    check("ovf_set", {31'd0, overflow}, 32'd1);
    repeat (5) @(negedge clk);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    cnt_q.push_back(16'd10); cnt_q.push_back(16'd20);
    push_frame(8'hA0, 8'h00, 8'h0F);
    run_start(2'd0);
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    wait_done(4, "done_c2");

    // tx_busy held high for 10 cycles at SEND entry
    cnt_q.push_back(16'd50); cnt_q.push_back(16'd52);
    push_frame(8'hA0, 8'h00, 8'h33);
    base_tx  = n_tx;
    base_win = n_win;
    run_start(2'd0);
    wait_win(base_win + 2, "win_d");
    hold_busy = 1'b1;
    repeat (10) @(negedge clk);
    check("tx_held", n_tx - base_tx, 0);
    check("busy_held", {31'd0, busy}, 32'd1);
    hold_busy = 1'b0;
    wait_done(5, "done_d");
    check("bytes_d", n_tx - base_tx, 3);

    // Abort during the second byte's TXWAIT, then a fresh run
    cnt_q.push_back(16'd7); cnt_q.push_back(16'd9);
    push_frame(8'hA0, 8'h00, 8'h08);
    base_tx = n_tx;
    dn = n_done;
    run_start(2'd0);
    wait_tx(base_tx + 2, "tx2_e");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {28'd0, busy, en_inv, cnt_en, done}, 32'd0);
    check("abort_q", exp_q.size(), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    cnt_q.push_back(16'd1); cnt_q.push_back(16'd3);
    push_frame(8'hA0, 8'h00, 8'h02);
    mode  = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("no_done_abort", n_done, dn);
    wait_done(dn + 1, "done_e");
    check("bytes_e", n_tx - base_tx, 5);
    repeat (5) @(negedge clk);
    check("done_once_e", n_done, dn + 1);

    // Reset in the middle of a gate window
    cnt_q.push_back(16'd5); cnt_q.push_back(16'd5);
    push_frame(8'hA0, 8'h00, 8'h05);
    run_start(2'd0);
    k = 0;
    while (!cnt_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("reach_gate_f", {31'd0, cnt_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("reset_mid_gate", {15'd0, outs()}, 32'd0);
    cnt_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_tx = n_tx;
    repeat (20) @(negedge clk);
    check("no_tx_after_reset", n_tx - base_tx, 0);
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    check("exp_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
